// File: rtl/irq_ctrl.sv
// Programmable interrupt controller: synchronizes sources into pending flags,
// prioritizes them by programmable level and drives registered IPL to the 68000.
module irq_ctrl #(
    parameter int unsigned NUM_SRC = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src_in,
    input  logic               cs,
    input  logic [1:0]         wr,
    input  logic [2:0]         address,
    input  logic [15:0]        din,
    output logic [15:0]        dout,
    input  logic [2:0]         cpu_fc,
    input  logic               cpu_as_n,
    input  logic [2:0]         iack_level,
    output logic [2:0]         ipl_n
);

    localparam int unsigned LW = 3 * NUM_SRC;

    localparam logic [2:0] A_ENABLE  = 3'd0;
    localparam logic [2:0] A_PENDING = 3'd1;
    localparam logic [2:0] A_MODE    = 3'd2;
    localparam logic [2:0] A_LEVEL   = 3'd3;
    localparam logic [2:0] A_STATUS  = 3'd4;
    localparam logic [2:0] A_FORCE   = 3'd5;

    logic [NUM_SRC-1:0] sync1, sync2, prev;
    logic [NUM_SRC-1:0] enable, mode, pending;
    logic [LW-1:0]      level;
    logic               spur;
    logic               iack_q;

    logic [15:0]        wmask, wdata;
    logic [NUM_SRC-1:0] edge_det, req, match, iack_clr, pset, pclr, pending_nxt;
    logic [2:0]         out_level, winner;
    logic               iack_cond, iack_det, found, spur_nxt;
    logic               unused_bits;

    assign wmask       = cs ? {{8{wr[1]}}, {8{wr[0]}}} : 16'h0000;
    assign wdata       = din & wmask;
    assign unused_bits = ^{wdata, wmask};

    assign edge_det  = sync2 & ~prev;
    assign iack_cond = ~cpu_as_n & (cpu_fc == 3'b111);
    assign iack_det  = iack_cond & ~iack_q;

    // Requests, highest-level winner (lowest index on ties) and IACK match
    always_comb begin
        req       = '0;
        match     = '0;
        iack_clr  = '0;
        out_level = 3'd0;
        winner    = 3'd0;
        found     = 1'b0;
        for (int s = 0; s < int'(NUM_SRC); s++) begin
            req[s]   = pending[s] & enable[s] & (level[3*s +: 3] != 3'd0);
            match[s] = req[s] & (level[3*s +: 3] == iack_level);
            if (req[s] && (level[3*s +: 3] > out_level)) begin
                out_level = level[3*s +: 3];
                winner    = 3'(s);
            end
            if (match[s] && mode[s] && !found) begin
                iack_clr[s] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    // Pending update: edge sources set-wins over clear, level sources track sync
    always_comb begin
        pset        = edge_det | ((address == A_FORCE) ? wdata[NUM_SRC-1:0] : '0);
        pclr        = ((address == A_PENDING) ? wdata[NUM_SRC-1:0] : '0)
                    | (iack_det ? iack_clr : '0);
        pending_nxt = '0;
        for (int s = 0; s < int'(NUM_SRC); s++) begin
            pending_nxt[s] = mode[s] ? (pset[s] | (pending[s] & ~pclr[s])) : sync2[s];
        end
        spur_nxt = (spur & ~((address == A_STATUS) & wdata[15])) | (iack_det & ~(|match));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1   <= '0;
            sync2   <= '0;
            prev    <= '0;
            enable  <= '0;
            mode    <= '0;
            pending <= '0;
            level   <= '0;
            spur    <= 1'b0;
            iack_q  <= 1'b0;
            ipl_n   <= 3'b111;
        end else begin
            sync1   <= src_in;
            sync2   <= sync1;
            prev    <= sync2;
            iack_q  <= iack_cond;
            pending <= pending_nxt;
            spur    <= spur_nxt;
            ipl_n   <= ~out_level;
            if (address == A_ENABLE)
                enable <= (enable & ~wmask[NUM_SRC-1:0]) | wdata[NUM_SRC-1:0];
            if (address == A_MODE)
                mode <= (mode & ~wmask[NUM_SRC-1:0]) | wdata[NUM_SRC-1:0];
            if (address == A_LEVEL)
                level <= (level & ~wmask[LW-1:0]) | wdata[LW-1:0];
        end
    end

    always_comb begin
        dout = 16'h0000;
        case (address)
            A_ENABLE:  dout = 16'(enable);
            A_PENDING: dout = 16'(pending);
            A_MODE:    dout = 16'(mode);
            A_LEVEL:   dout = 16'(level);
            A_STATUS:  dout = {spur, 7'd0, |req, winner, 1'b0, out_level};
            default:   dout = 16'h0000;
        endcase
    end

endmodule
